// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: bit timing, decode thresholds, receiver state
// encoding and word/address widths used by ws2812_in and ws2812_out.
package ws2812_pkg;

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned WORD_W    = 16;
  localparam int unsigned ADDR_W    = 13;
  localparam int unsigned BIT_CNT_W = 4;

  // Transmit bit timing in 24 MHz cycles
  localparam int unsigned T0H_CYCLES   = 7;
  localparam int unsigned T1H_CYCLES   = 26;
  localparam int unsigned T0L_CYCLES   = 26;
  localparam int unsigned T1L_CYCLES   = 7;
  localparam int unsigned LATCH_CYCLES = 1200;

  localparam int unsigned WORD_COUNT_DEF = 1305;
  localparam int unsigned THRESHOLD_DEF  = 16;
  localparam int unsigned MIN_HIGH_DEF   = 3;
  localparam int unsigned MAX_HIGH_DEF   = 48;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } word_wr_t;

  typedef struct packed {
    logic glitch;
    logic stuck;
    logic partial;
    logic overflow;
  } err_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ws2812_in_sync.sv
// Two-flop synchronizer for the WS2812 line with rise/fall detection on the
// synchronized level.
module ws2812_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic data_i,
  output logic line_o,
  output logic rise_o_c,
  output logic fall_o_c
);

  logic meta_q, line_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      line_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= data_i;
      line_q <= meta_q;
      prev_q <= line_q;
    end
  end

  assign line_o   = line_q;
  assign rise_o_c = line_q & ~prev_q;
  assign fall_o_c = ~line_q & prev_q;

endmodule

// File: rtl/ws2812_in.sv
// WS2812 receiver: measures high pulse widths, decodes bits MSB-first into
// 16-bit words and writes them out with a per-frame word address.
module ws2812_in
  import ws2812_pkg::*;
#(
  parameter int unsigned WORD_COUNT  = WORD_COUNT_DEF,
  parameter int unsigned THRESHOLD   = THRESHOLD_DEF,
  parameter int unsigned MIN_HIGH    = MIN_HIGH_DEF,
  parameter int unsigned MAX_HIGH    = MAX_HIGH_DEF,
  parameter int unsigned LATCH_COUNT = LATCH_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in_i,
  output logic [WORD_W-1:0] word_data_o,
  output logic [ADDR_W-1:0] word_address_o,
  output logic              word_strobe_o,
  output logic              frame_done_o,
  output logic [ADDR_W-1:0] frame_words_o,
  output logic              err_glitch_o,
  output logic              err_stuck_o,
  output logic              err_partial_o,
  output logic              err_overflow_o
);

  localparam logic [CNT_W-1:0]  THRESH_C = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0]  MIN_C    = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0]  MAX_C    = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0]  LATCH_C  = CNT_W'(LATCH_COUNT);
  localparam logic [ADDR_W-1:0] WORDS_C  = ADDR_W'(WORD_COUNT);

  logic line_s, rise_c, fall_c;

  ws2812_in_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .data_i   (data_in_i),
    .line_o   (line_s),
    .rise_o_c (rise_c),
    .fall_o_c (fall_c)
  );

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_W-1:0]      shift_q, shift_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  word_wr_t               wr_q, wr_d;
  logic                   strobe_q, strobe_d;
  logic                   done_q, done_d;
  logic [ADDR_W-1:0]      fw_q, fw_d;
  err_t                   err_q, err_d;

  logic [CNT_W-1:0]  cnt_inc;
  logic [WORD_W-1:0] word_v;

  assign cnt_inc = sat_inc(cnt_q);
  // Width at the falling edge is cnt_q; the new bit lands in the LSB
  assign word_v  = {shift_q[WORD_W-2:0], (cnt_q >= THRESH_C)};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    fw_d      = fw_q;
    err_d     = err_q;

    unique case (state_q)
      // Wait for a full latch-length low so decoding never starts mid-frame
      ST_SYNC: begin
        if (line_s) begin
          cnt_d = '0;
        end else if (cnt_inc >= LATCH_C) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_IDLE: begin
        addr_d    = '0;
        bit_cnt_d = '0;
        if (rise_c) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_W'(1);
          err_d   = '0;
        end
      end
      ST_HIGH: begin
        if (fall_c) begin
          state_d = ST_LOW;
          cnt_d   = CNT_W'(1);
          if (cnt_q < MIN_C) begin
            err_d.glitch = 1'b1;
          end else begin
            shift_d   = word_v;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == '1) begin
              if (addr_q < WORDS_C) begin
                strobe_d = 1'b1;
                wr_d     = '{addr: addr_q, data: word_v};
                addr_d   = addr_q + ADDR_W'(1);
              end else begin
                err_d.overflow = 1'b1;
              end
            end
          end
        end else if (cnt_inc >= MAX_C) begin
          err_d.stuck = 1'b1;
          cnt_d       = '0;
          state_d     = ST_SYNC;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_LOW: begin
        if (rise_c) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_W'(1);
        end else if (cnt_inc >= LATCH_C) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          fw_d    = addr_q;
          if (bit_cnt_q != '0) err_d.partial = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_SYNC;
      cnt_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      wr_q      <= '0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
      fw_q      <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
      fw_q      <= fw_d;
      err_q     <= err_d;
    end
  end

  assign word_data_o    = wr_q.data;
  assign word_address_o = wr_q.addr;
  assign word_strobe_o  = strobe_q;
  assign frame_done_o   = done_q;
  assign frame_words_o  = fw_q;
  assign err_glitch_o   = err_q.glitch;
  assign err_stuck_o    = err_q.stuck;
  assign err_partial_o  = err_q.partial;
  assign err_overflow_o = err_q.overflow;

endmodule

// File: tb/tb_ws2812_in.sv
// Self-checking bench for ws2812_in: drives pulse trains on the line and
// compares strobes, frame results and error flags with a pulse-width model.
module tb_ws2812_in;

  localparam int LATCH = 1200;
  localparam int MINH  = 3;
  localparam int THR   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;

  logic [15:0] a_wd, b_wd;
  logic [12:0] a_wa, b_wa, a_fwo, b_fwo;
  logic a_ws, a_fd, a_eg, a_es, a_ep, a_eo;
  logic b_ws, b_fd, b_eg, b_es, b_ep, b_eo;

  ws2812_in dut_a (
    .clk(clk), .rst(rst), .data_in_i(din),
    .word_data_o(a_wd), .word_address_o(a_wa), .word_strobe_o(a_ws),
    .frame_done_o(a_fd), .frame_words_o(a_fwo),
    .err_glitch_o(a_eg), .err_stuck_o(a_es), .err_partial_o(a_ep), .err_overflow_o(a_eo)
  );

  ws2812_in #(.WORD_COUNT(2)) dut_b (
    .clk(clk), .rst(rst), .data_in_i(din),
    .word_data_o(b_wd), .word_address_o(b_wa), .word_strobe_o(b_ws),
    .frame_done_o(b_fd), .frame_words_o(b_fwo),
    .err_glitch_o(b_eg), .err_stuck_o(b_es), .err_partial_o(b_ep), .err_overflow_o(b_eo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Observed write-port activity
  logic [15:0] a_data[$], b_data[$];
  logic [12:0] a_addr[$], b_addr[$];
  int          a_scyc[$];
  int          a_done = 0, b_done = 0;
  logic [12:0] a_fw = '0, b_fw = '0;

  always @(negedge clk) begin
    if (a_ws) begin a_data.push_back(a_wd); a_addr.push_back(a_wa); a_scyc.push_back(cyc); end
    if (b_ws) begin b_data.push_back(b_wd); b_addr.push_back(b_wa); end
    if (a_fd) begin a_done = a_done + 1; a_fw = a_fwo; end
    if (b_fd) begin b_done = b_done + 1; b_fw = b_fwo; end
  end

  // Stimulus record and model results
  int          pulses[$];
  int          fall_cyc = 0;
  logic [15:0] exp_w[$];
  logic        m_glitch, m_partial, m_over;
  int          m_fw;

  task automatic clear_frame();
    a_data.delete(); a_addr.delete(); a_scyc.delete(); b_data.delete(); b_addr.delete();
    a_done = 0; b_done = 0;
    pulses.delete();
  endtask

  task automatic pulse(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    fall_cyc = cyc;
    pulses.push_back(hi);
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(26, 7);
    else   pulse(7, 26);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic latch_gap();
    din = 1'b0;
    repeat (LATCH + 10) @(negedge clk);
  endtask

  // Frame model: filter glitches, classify widths, chunk bits into words
  task automatic model(input int wc);
    logic bits[$];
    int   nfull;
    logic [15:0] w;
    m_glitch = 1'b0;
    exp_w.delete();
    foreach (pulses[i]) begin
      if (pulses[i] < MINH) m_glitch = 1'b1;
      else bits.push_back(pulses[i] >= THR);
    end
    nfull     = bits.size() / 16;
    m_partial = (bits.size() % 16) != 0;
    m_over    = nfull > wc;
    m_fw      = (nfull > wc) ? wc : nfull;
    for (int k = 0; k < m_fw; k++) begin
      w = '0;
      for (int j = 0; j < 16; j++) w[15-j] = bits[16*k + j];
      exp_w.push_back(w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({a_wd, a_wa, a_ws, a_fd, a_fwo, a_eg, a_es, a_ep, a_eo} !== '0) begin
      $display("FAIL reset_a: got %h %h %b %b %h %b%b%b%b want all zero",
               a_wd, a_wa, a_ws, a_fd, a_fwo, a_eg, a_es, a_ep, a_eo);
      fails++;
    end
    tests++;
    if ({b_wd, b_wa, b_ws, b_fd, b_fwo, b_eg, b_es, b_ep, b_eo} !== '0) begin
      $display("FAIL reset_b: outputs not zero during reset");
      fails++;
    end
    rst = 1'b0;
    latch_gap();
  endtask

  task automatic test_basic();
    clear_frame();
    send_word(16'hA5C3);
    latch_gap();
    tests++;
    if (a_data.size() != 1) begin
      $display("FAIL basic_count: got %0d strobes want 1", a_data.size()); fails++;
    end else begin
      tests++;
      if (a_data[0] !== 16'hA5C3 || a_addr[0] !== 13'd0) begin
        $display("FAIL basic_word: got %h@%0d want a5c3@0", a_data[0], a_addr[0]); fails++;
      end
      tests++;
      if (a_scyc[0] - fall_cyc != 3) begin
        $display("FAIL basic_latency: got %0d cycles want 3", a_scyc[0] - fall_cyc); fails++;
      end
    end
    tests++;
    if (a_done != 1 || a_fw !== 13'd1) begin
      $display("FAIL basic_done: got %0d dones fw=%0d want 1 fw=1", a_done, a_fw); fails++;
    end
    tests++;
    if ({a_eg, a_es, a_ep, a_eo} !== 4'b0000 || a_wd !== 16'hA5C3) begin
      $display("FAIL basic_hold: got err=%b%b%b%b data=%h want 0000 a5c3", a_eg, a_es, a_ep, a_eo, a_wd);
      fails++;
    end
  endtask

  task automatic test_sync_start();
    rst = 1'b1; din = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    clear_frame();
    send_word(16'h00FF);
    latch_gap();
    tests++;
    if (a_data.size() != 0 || a_done != 0) begin
      $display("FAIL sync_start_nodecode: got %0d strobes %0d dones want 0 0", a_data.size(), a_done);
      fails++;
    end
    clear_frame();
    send_word(16'h5A5A);
    latch_gap();
    tests++;
    if (a_data.size() != 1 || a_done != 1) begin
      $display("FAIL sync_start_next: got %0d strobes %0d dones want 1 1", a_data.size(), a_done);
      fails++;
    end else begin
      tests++;
      if (a_data[0] !== 16'h5A5A) begin
        $display("FAIL sync_start_word: got %h want 5a5a", a_data[0]); fails++;
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      clear_frame();
      send_word(16'h0001); send_word(16'hFFFF); send_word(16'h8000);
      latch_gap();
      model(1305);
      tests++;
      if (a_data.size() != 3 || a_done != 1 || a_fw !== 13'd3) begin
        $display("FAIL b2b_frame%0d: got %0d strobes %0d dones fw=%0d want 3 1 3", f, a_data.size(), a_done, a_fw);
        fails++;
      end else begin
        for (int k = 0; k < 3; k++) begin
          tests++;
          if (a_data[k] !== exp_w[k] || a_addr[k] !== 13'(k)) begin
            $display("FAIL b2b_word%0d_%0d: got %h@%0d want %h@%0d", f, k, a_data[k], a_addr[k], exp_w[k], k);
            fails++;
          end
        end
      end
    end
  endtask

  task automatic test_glitch_partial();
    logic [15:0] w = 16'h1234;
    logic [7:0]  t = 8'hC3;
    clear_frame();
    for (int i = 15; i >= 0; i--) begin
      send_bit(w[i]);
      if (i == 8) pulse(2, 10);
    end
    for (int i = 7; i >= 0; i--) send_bit(t[i]);
    latch_gap();
    tests++;
    if (a_data.size() != 1 || a_done != 1 || a_fw !== 13'd1) begin
      $display("FAIL glitch_count: got %0d strobes %0d dones fw=%0d want 1 1 1", a_data.size(), a_done, a_fw);
      fails++;
    end else begin
      tests++;
      if (a_data[0] !== 16'h1234) begin
        $display("FAIL glitch_word: got %h want 1234", a_data[0]); fails++;
      end
    end
    tests++;
    if ({a_eg, a_es, a_ep, a_eo} !== 4'b1010) begin
      $display("FAIL glitch_flags: got %b%b%b%b want 1010", a_eg, a_es, a_ep, a_eo); fails++;
    end
    clear_frame();
    send_bit(1'b1);
    tests++;
    if ({a_eg, a_es, a_ep, a_eo} !== 4'b0000) begin
      $display("FAIL glitch_clear: got %b%b%b%b want 0000", a_eg, a_es, a_ep, a_eo); fails++;
    end
    for (int i = 14; i >= 0; i--) send_bit(i == 0);
    latch_gap();
    tests++;
    if (a_data.size() != 1 || a_done != 1) begin
      $display("FAIL glitch_next: got %0d strobes %0d dones want 1 1", a_data.size(), a_done);
      fails++;
    end else begin
      tests++;
      if (a_data[0] !== 16'h8001) begin
        $display("FAIL glitch_next_word: got %h want 8001", a_data[0]); fails++;
      end
    end
  endtask

  task automatic test_boundary();
    int pat[4] = '{3, 15, 16, 47};
    clear_frame();
    pulse(2, 5);
    for (int i = 0; i < 16; i++) pulse(pat[i % 4], 3);
    latch_gap();
    tests++;
    if (a_data.size() != 1) begin
      $display("FAIL boundary_count: got %0d strobes want 1", a_data.size()); fails++;
    end else begin
      tests++;
      if (a_data[0] !== 16'h3333) begin
        $display("FAIL boundary_word: got %h want 3333", a_data[0]); fails++;
      end
    end
    tests++;
    if ({a_eg, a_es, a_ep, a_eo} !== 4'b1000) begin
      $display("FAIL boundary_flags: got %b%b%b%b want 1000", a_eg, a_es, a_ep, a_eo); fails++;
    end
  endtask

  task automatic test_overflow();
    logic [15:0] w[3];
    clear_frame();
    for (int k = 0; k < 3; k++) begin
      w[k] = 16'($urandom);
      send_word(w[k]);
    end
    latch_gap();
    tests++;
    if (b_data.size() != 2 || b_done != 1 || b_fw !== 13'd2) begin
      $display("FAIL ovf_count: got %0d strobes %0d dones fw=%0d want 2 1 2", b_data.size(), b_done, b_fw);
      fails++;
    end else begin
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (b_data[k] !== w[k] || b_addr[k] !== 13'(k)) begin
          $display("FAIL ovf_word%0d: got %h@%0d want %h@%0d", k, b_data[k], b_addr[k], w[k], k);
          fails++;
        end
      end
    end
    tests++;
    if (b_eo !== 1'b1 || a_eo !== 1'b0 || a_data.size() != 3) begin
      $display("FAIL ovf_flag: got b=%b a=%b a_strobes=%0d want 1 0 3", b_eo, a_eo, a_data.size());
      fails++;
    end
  endtask

  task automatic test_stuck();
    clear_frame();
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    din = 1'b1;
    repeat (60) @(negedge clk);
    tests++;
    if (a_es !== 1'b1) begin
      $display("FAIL stuck_flag: got %b want 1", a_es); fails++;
    end
    din = 1'b0;
    repeat (300) @(negedge clk);
    send_word(16'hBEEF);
    latch_gap();
    tests++;
    if (a_data.size() != 0 || a_done != 0 || a_es !== 1'b1) begin
      $display("FAIL stuck_resync: got %0d strobes %0d dones stuck=%b want 0 0 1", a_data.size(), a_done, a_es);
      fails++;
    end
    clear_frame();
    send_word(16'h0F0F);
    latch_gap();
    tests++;
    if (a_data.size() != 1 || a_done != 1 || a_es !== 1'b0) begin
      $display("FAIL stuck_resume: got %0d strobes %0d dones stuck=%b want 1 1 0", a_data.size(), a_done, a_es);
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    clear_frame();
    for (int i = 0; i < 8; i++) send_bit(i[1]);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({a_wd, a_wa, a_ws, a_fd, a_fwo, a_eg, a_es, a_ep, a_eo} !== '0) begin
      $display("FAIL rst_mid_outputs: got data=%h addr=%0d fw=%0d want all zero", a_wd, a_wa, a_fwo);
      fails++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    latch_gap();
    tests++;
    if (a_data.size() != 0 || a_done != 0) begin
      $display("FAIL rst_mid_nostrobe: got %0d strobes %0d dones want 0 0", a_data.size(), a_done);
      fails++;
    end
  endtask

  task automatic test_random();
    int nbits, got, hi;
    logic b;
    for (int f = 0; f < 5; f++) begin
      clear_frame();
      nbits = 16 * $urandom_range(1, 3) + $urandom_range(0, 2);
      got = 0;
      while (got < nbits) begin
        if ($urandom_range(0, 9) == 0) begin
          hi = $urandom_range(1, 2);
        end else begin
          b  = 1'($urandom);
          hi = b ? $urandom_range(16, 47) : $urandom_range(3, 15);
          got++;
        end
        pulse(hi, $urandom_range(2, 30));
      end
      latch_gap();
      model(1305);
      tests++;
      if (a_data.size() != exp_w.size() || a_done != 1 || a_fw !== 13'(m_fw)) begin
        $display("FAIL rand%0d_count: got %0d strobes %0d dones fw=%0d want %0d 1 %0d",
                 f, a_data.size(), a_done, a_fw, exp_w.size(), m_fw);
        fails++;
      end else begin
        foreach (exp_w[k]) begin
          tests++;
          if (a_data[k] !== exp_w[k] || a_addr[k] !== 13'(k)) begin
            $display("FAIL rand%0d_word%0d: got %h@%0d want %h@%0d", f, k, a_data[k], a_addr[k], exp_w[k], k);
            fails++;
          end
        end
      end
      tests++;
      if ({a_eg, a_es, a_ep, a_eo} !== {m_glitch, 1'b0, m_partial, m_over}) begin
        $display("FAIL rand%0d_flags: got %b%b%b%b want %b0%b%b", f, a_eg, a_es, a_ep, a_eo, m_glitch, m_partial, m_over);
        fails++;
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_sync_start();
    test_back_to_back();
    test_glitch_partial();
    test_boundary();
    test_overflow();
    test_stuck();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
